// File: rtl/tb_mem_pkg.sv
// Shared constants and helpers for the multi-channel write-arbitrated memory.
package tb_mem_pkg;

    // StallPeriod value that disables ready throttling.
    localparam int unsigned StallOff = 0;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating priority pointer.
module tb_rr_arbiter
    import tb_mem_pkg::*;
#(
    parameter int unsigned NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              ack_i,
    output logic [NumReq-1:0] grant_o
);

    localparam int unsigned IdxW = ch_idx_width(NumReq);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        grant_o = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NumReq);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                win_idx       = cand;
            end
        end
    end

    // Pointer moves past the winner only when the grant was actually used.
    always_comb begin
        ptr_d = ptr_q;
        if (ack_i) begin
            ptr_d = (32'(win_idx) == NumReq - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tb_wr_memory_arb.sv
// Word memory with a combinational read port and round-robin arbitrated
// per-channel auto-incrementing write ports, optional periodic ready throttling.
module tb_wr_memory_arb
    import tb_mem_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned MemDepth    = 1024,
    parameter int unsigned NumChannels = 2,
    parameter int unsigned StallPeriod = StallOff
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   en_i,
    input  logic [AddrWidth-1:0]                   rd_addr_i,
    output logic [DataWidth-1:0]                   rd_data_o,
    input  logic                                   set_wr_en_i,
    input  logic [ch_idx_width(NumChannels)-1:0]   set_wr_ch_i,
    input  logic [AddrWidth-1:0]                   set_wr_addr_i,
    output logic [NumChannels-1:0][AddrWidth-1:0]  wr_acc_addr_o,
    input  logic [NumChannels-1:0][DataWidth-1:0]  wr_acc_data_i,
    input  logic [NumChannels-1:0]                 wr_acc_valid_i,
    output logic [NumChannels-1:0]                 wr_acc_ready_o,
    output logic [NumChannels-1:0]                 wrap_o,
    output logic [31:0]                            wr_count_o
);

    localparam int unsigned MemAw = $clog2(MemDepth);

    logic [DataWidth-1:0]                  mem_q [MemDepth];
    logic [NumChannels-1:0][AddrWidth-1:0] addr_q, addr_d;
    logic [NumChannels-1:0]                wrap_q, wrap_d;
    logic [31:0]                           count_q, count_d;
    logic [31:0]                           stall_cnt_q, stall_cnt_d;
    logic                                  stall;

    logic [NumChannels-1:0] req, grant, success;
    logic                   ack;
    logic                   wr_en;
    logic [MemAw-1:0]       wr_idx;
    logic [DataWidth-1:0]   wr_data;

    assign req = en_i ? wr_acc_valid_i : '0;

    tb_rr_arbiter #(
        .NumReq (NumChannels)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req),
        .ack_i   (ack),
        .grant_o (grant)
    );

    assign wr_acc_ready_o = (en_i && !stall) ? grant : '0;
    assign success        = wr_acc_valid_i & wr_acc_ready_o;
    assign ack            = |success;

    always_comb begin
        stall       = (StallPeriod != StallOff) && (stall_cnt_q == 32'(StallPeriod - 1));
        stall_cnt_d = stall_cnt_q;
        if (en_i && StallPeriod != StallOff) begin
            stall_cnt_d = stall ? '0 : stall_cnt_q + 1;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wrap_d  = wrap_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (success[c]) begin
                wr_en   = 1'b1;
                wr_idx  = MemAw'(addr_q[c]);
                wr_data = wr_acc_data_i[c];
                if (addr_q[c] == AddrWidth'(MemDepth - 1)) begin
                    addr_d[c] = '0;
                    wrap_d[c] = 1'b1;
                end else begin
                    addr_d[c] = addr_q[c] + 1'b1;
                end
            end
        end
        if (wr_en && count_q != '1) begin
            count_d = count_q + 1;
        end
        // A load wins over the increment; the write above already used the old address.
        if (set_wr_en_i && 32'(set_wr_ch_i) < NumChannels) begin
            addr_d[set_wr_ch_i] = set_wr_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MemDepth); i++) begin
                mem_q[i] <= '0;
            end
            addr_q      <= '0;
            wrap_q      <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= wr_data;
            end
            addr_q      <= addr_d;
            wrap_q      <= wrap_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rd_data_o     = mem_q[MemAw'(rd_addr_i)];
    assign wr_acc_addr_o = addr_q;
    assign wrap_o        = wrap_q;
    assign wr_count_o    = count_q;

endmodule

// File: tb/tb_tb_wr_memory_arb.sv
// Bench: two DUT configurations driven in lockstep against a behavioural model.
`timescale 1ns/1ps
module tb_tb_wr_memory_arb;

    localparam int NC0 = 2;
    localparam int NC1 = 3;
    localparam int MD0 = 1024;
    localparam int MD1 = 16;
    localparam int SP1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_v [2];
    logic        en_v [2];
    logic        set_en_v [2];
    int unsigned set_ch_v [2];
    logic [31:0] set_addr_v [2];
    logic [31:0] rd_addr_v [2];
    logic [7:0]  valid_v [2];
    logic [31:0] data_v [2][8];

    logic [1:0][31:0] data_a, addr_a;
    logic [1:0]       ready_a, wrap_a;
    logic [31:0]      rdd_a, cnt_a;
    logic [2:0][31:0] data_b, addr_b;
    logic [2:0]       ready_b, wrap_b;
    logic [31:0]      rdd_b, cnt_b;

    assign data_a = {data_v[0][1], data_v[0][0]};
    assign data_b = {data_v[1][2], data_v[1][1], data_v[1][0]};

    tb_wr_memory_arb dut_a (
        .clk_i          (clk),
        .rst_i          (rst_v[0]),
        .en_i           (en_v[0]),
        .rd_addr_i      (rd_addr_v[0]),
        .rd_data_o      (rdd_a),
        .set_wr_en_i    (set_en_v[0]),
        .set_wr_ch_i    (1'(set_ch_v[0])),
        .set_wr_addr_i  (set_addr_v[0]),
        .wr_acc_addr_o  (addr_a),
        .wr_acc_data_i  (data_a),
        .wr_acc_valid_i (valid_v[0][1:0]),
        .wr_acc_ready_o (ready_a),
        .wrap_o         (wrap_a),
        .wr_count_o     (cnt_a)
    );

    tb_wr_memory_arb #(
        .MemDepth    (MD1),
        .NumChannels (NC1),
        .StallPeriod (SP1)
    ) dut_b (
        .clk_i          (clk),
        .rst_i          (rst_v[1]),
        .en_i           (en_v[1]),
        .rd_addr_i      (rd_addr_v[1]),
        .rd_data_o      (rdd_b),
        .set_wr_en_i    (set_en_v[1]),
        .set_wr_ch_i    (2'(set_ch_v[1])),
        .set_wr_addr_i  (set_addr_v[1]),
        .wr_acc_addr_o  (addr_b),
        .wr_acc_data_i  (data_b),
        .wr_acc_valid_i (valid_v[1][2:0]),
        .wr_acc_ready_o (ready_b),
        .wrap_o         (wrap_b),
        .wr_count_o     (cnt_b)
    );

    // Behavioural model state.
    logic [31:0] mmem [2][1024];
    logic [31:0] maddr [2][8];
    logic [7:0]  mwrap [2];
    logic [31:0] mcnt [2];
    int          mptr [2];
    int          men [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        for (int a = 0; a < 1024; a++) mmem[i][a] = '0;
        for (int c = 0; c < 8; c++) maddr[i][c] = '0;
        mwrap[i] = '0;
        mcnt[i]  = '0;
        mptr[i]  = 0;
        men[i]   = 0;
    endtask

    task automatic check_and_step(input int i);
        int nc, md, sp, g;
        bit stall;
        logic [7:0]  exp_rdy, act_rdy, act_wrap;
        logic [31:0] act_addr [8];
        logic [31:0] act_rd, act_cnt;
        nc = (i == 0) ? NC0 : NC1;
        md = (i == 0) ? MD0 : MD1;
        sp = (i == 0) ? 0 : SP1;
        for (int c = 0; c < 8; c++) act_addr[c] = '0;
        if (i == 0) begin
            act_rdy = 8'(ready_a); act_wrap = 8'(wrap_a); act_rd = rdd_a; act_cnt = cnt_a;
            for (int c = 0; c < NC0; c++) act_addr[c] = addr_a[c];
        end else begin
            act_rdy = 8'(ready_b); act_wrap = 8'(wrap_b); act_rd = rdd_b; act_cnt = cnt_b;
            for (int c = 0; c < NC1; c++) act_addr[c] = addr_b[c];
        end
        // Every N-th enabled cycle is a stall cycle.
        stall = (sp != 0) && (men[i] % sp == sp - 1);
        g = -1;
        if (en_v[i]) begin
            for (int k = 0; k < nc; k++) begin
                int c;
                c = (mptr[i] + k) % nc;
                if (g < 0 && valid_v[i][c]) g = c;
            end
        end
        exp_rdy = (g >= 0 && !stall) ? 8'(1 << g) : 8'h00;
        check($sformatf("ready[dut%0d]", i), 32'(act_rdy), 32'(exp_rdy));
        for (int c = 0; c < nc; c++)
            check($sformatf("addr[dut%0d][%0d]", i, c), act_addr[c], maddr[i][c]);
        check($sformatf("wrap[dut%0d]", i), 32'(act_wrap), 32'(mwrap[i]));
        check($sformatf("count[dut%0d]", i), act_cnt, mcnt[i]);
        check($sformatf("rd_data[dut%0d]", i), act_rd, mmem[i][rd_addr_v[i] % md]);
        if (rst_v[i]) begin
            model_reset(i);
            return;
        end
        if (exp_rdy != 0) begin
            mmem[i][maddr[i][g] % md] = data_v[i][g];
            if (maddr[i][g] == md - 1) begin
                maddr[i][g] = '0;
                mwrap[i][g] = 1'b1;
            end else begin
                maddr[i][g] = maddr[i][g] + 1;
            end
            if (mcnt[i] != 32'hFFFF_FFFF) mcnt[i] = mcnt[i] + 1;
            mptr[i] = (g + 1) % nc;
        end
        if (en_v[i]) men[i]++;
        if (set_en_v[i] && set_ch_v[i] < nc) maddr[i][set_ch_v[i]] = set_addr_v[i];
    endtask

    task automatic cycle();
        #1;
        check_and_step(0);
        check_and_step(1);
        @(negedge clk);
    endtask

    task automatic idle(input int i);
        rst_v[i] = 1'b0; en_v[i] = 1'b0; valid_v[i] = '0; set_en_v[i] = 1'b0;
        set_ch_v[i] = 0; set_addr_v[i] = '0; rd_addr_v[i] = '0;
    endtask

    task automatic rd_pin(input int i, input logic [31:0] addr, input logic [31:0] exp,
                          input string name);
        rd_addr_v[i] = addr;
        #1;
        check(name, (i == 0) ? rdd_a : rdd_b, exp);
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            idle(i);
            rst_v[i] = 1'b1;
            for (int c = 0; c < 8; c++) data_v[i][c] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset(0);
        model_reset(1);
        idle(0);
        idle(1);

        // Reset state.
        check("reset count", cnt_a, 32'd0);
        check("reset wrap", 32'(wrap_a), 32'd0);
        rd_pin(0, 32'd7, 32'd0, "reset rd");

        // Two channels both valid: grants alternate and addresses interleave.
        for (int k = 0; k < 4; k++) begin
            en_v[0] = 1'b1; valid_v[0] = 8'h03;
            data_v[0][0] = 32'hA0 + k; data_v[0][1] = 32'hB0 + k;
            #1;
            check("alt grant", 32'(ready_a), (k % 2 == 0) ? 32'd1 : 32'd2);
            cycle();
        end
        idle(0);
        rd_pin(0, 32'd0, 32'hB1, "alt mem0");
        rd_pin(0, 32'd1, 32'hB3, "alt mem1");
        check("alt count", cnt_a, 32'd4);
        check("alt addr0", addr_a[0], 32'd2);
        check("alt addr1", addr_a[1], 32'd2);

        // Address wrap on channel 0.
        en_v[0] = 1'b1; set_en_v[0] = 1'b1; set_ch_v[0] = 0; set_addr_v[0] = 32'd1022;
        cycle();
        set_en_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_v[0] = 8'h01; data_v[0][0] = 32'h100 + k;
            cycle();
        end
        idle(0);
        check("wrap flag", 32'(wrap_a), 32'd1);
        check("wrap addr", addr_a[0], 32'd1);
        rd_pin(0, 32'd1022, 32'h100, "wrap mem1022");
        rd_pin(0, 32'd1023, 32'h101, "wrap mem1023");
        rd_pin(0, 32'd0, 32'h102, "wrap mem0");

        // Address load in the same cycle as a write uses the old address.
        en_v[0] = 1'b1; set_en_v[0] = 1'b1; set_ch_v[0] = 1; set_addr_v[0] = 32'd5;
        cycle();
        valid_v[0] = 8'h02; data_v[0][1] = 32'h55; set_addr_v[0] = 32'h10;
        rd_addr_v[0] = 32'd5;
        #1;
        check("set+wr ready", 32'(ready_a), 32'd2);
        check("set+wr pre-write rd", rdd_a, 32'd0);
        cycle();
        idle(0);
        check("set+wr addr", addr_a[1], 32'h10);
        rd_pin(0, 32'd5, 32'h55, "set+wr mem5");

        // Enable low: nothing moves.
        for (int k = 0; k < 5; k++) begin
            en_v[0] = 1'b0; valid_v[0] = 8'h03; data_v[0][0] = 32'hDEAD; data_v[0][1] = 32'hBEEF;
            #1;
            check("en low ready", 32'(ready_a), 32'd0);
            cycle();
        end
        idle(0);
        check("en low count", cnt_a, 32'd8);
        rd_pin(0, 32'h10, 32'd0, "en low mem16");
        en_v[0] = 1'b1; valid_v[0] = 8'h03;
        #1;
        check("en low ptr held", 32'(ready_a), 32'd1);
        cycle();
        idle(0);

        // Throttled single channel: 12 enabled cycles give 9 writes.
        rst_v[1] = 1'b1;
        cycle();
        rst_v[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            en_v[1] = 1'b1; valid_v[1] = 8'h01; data_v[1][0] = 32'(k + 1);
            #1;
            check("stall ready", 32'(ready_b), (k % 4 == 3) ? 32'd0 : 32'd1);
            cycle();
        end
        idle(1);
        check("stall count", cnt_b, 32'd9);
        for (int k = 0; k < 5; k++) begin
            valid_v[1] = 8'h01;
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            en_v[1] = 1'b1; valid_v[1] = 8'h01;
            #1;
            check("stall frozen", 32'(ready_b), (k == 3) ? 32'd0 : 32'd1);
            cycle();
        end
        idle(1);
        set_en_v[1] = 1'b1; set_ch_v[1] = 3; set_addr_v[1] = 32'd7;
        cycle();
        idle(1);
        check("bad ch ignored", addr_b[2], 32'd0);

        // Reset mid-burst discards the in-flight write.
        for (int k = 0; k < 3; k++) begin
            en_v[0] = 1'b1; valid_v[0] = 8'h03;
            data_v[0][0] = $urandom; data_v[0][1] = $urandom;
            rst_v[0] = (k == 2);
            cycle();
        end
        idle(0);
        check("rst count", cnt_a, 32'd0);
        check("rst wrap", 32'(wrap_a), 32'd0);
        check("rst addr0", addr_a[0], 32'd0);
        check("rst addr1", addr_a[1], 32'd0);
        rd_pin(0, 32'd0, 32'd0, "rst mem0");
        rd_pin(0, 32'd1, 32'd0, "rst mem1");
        rd_pin(0, 32'd5, 32'd0, "rst mem5");
        rd_pin(0, 32'd1022, 32'd0, "rst mem1022");
        rd_pin(0, 32'd1023, 32'd0, "rst mem1023");

        // Randomized traffic on both configurations.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                int nc, md;
                nc = (i == 0) ? NC0 : NC1;
                md = (i == 0) ? MD0 : MD1;
                rst_v[i]    = ($urandom % 150 == 0);
                en_v[i]     = ($urandom % 4 != 0);
                valid_v[i]  = 8'($urandom);
                for (int c = 0; c < 8; c++) data_v[i][c] = $urandom;
                set_en_v[i] = ($urandom % 8 == 0);
                set_ch_v[i] = $urandom % ((i == 0) ? 2 : 4);
                set_addr_v[i] = ($urandom % 3 == 0) ? 32'(md - 1 - int'($urandom % 2))
                                                    : 32'($urandom % (md + 4));
                rd_addr_v[i] = ($urandom % 2 == 0) ? maddr[i][$urandom % nc]
                                                   : 32'($urandom % (2 * md));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
